// File: rtl/fpu_dispatch_pkg.sv
// rtl/fpu_dispatch_pkg.sv - shared types and constants for the FPU dispatch queue
package fpu_dispatch_pkg;

  // Reset value of every unit's operand registers (single-precision 1.0)
  localparam logic [31:0] FPU_ONE = 32'h3f800000;

  // Field widths of a request in the default configuration
  localparam int REQ_WIDTH   = 32;
  localparam int REQ_FUNCT_W = 5;
  localparam int REQ_TAG_W   = 5;

  // One queued core request, packed in queue order {funct, val1, val2, tag}
  typedef struct packed {
    logic [REQ_FUNCT_W-1:0] funct;
    logic [REQ_WIDTH-1:0]   val1;
    logic [REQ_WIDTH-1:0]   val2;
    logic [REQ_TAG_W-1:0]   tag;
  } fpu_req_t;

  // Life cycle of one FPU unit slot
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_state_t;

endpackage

// File: rtl/fpu_dispatch_fifo.sv
// rtl/fpu_dispatch_fifo.sv - circular request queue with wrap-bit pointers
module fpu_dispatch_fifo #(
  parameter int DATA_W = 47,
  parameter int DEPTH  = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_do_push;
  logic              w_do_pop;

  // A full queue refuses pushes even when a pop happens in the same cycle
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Read and write pointers, cleared by reset
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fpu_dispatch_queue.sv
// rtl/fpu_dispatch_queue.sv - in-order FP request dispatch to NUM_UNITS FPUs; FPU_DISPATCH_PERF_EN adds perf counters
module fpu_dispatch_queue
  import fpu_dispatch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FUNCT_W   = 5,
  parameter int TAG_W     = 5,
  parameter int NUM_UNITS = 2,
  parameter int DEPTH     = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [FUNCT_W-1:0]           req_funct,
  input  logic [WIDTH-1:0]             req_val1,
  input  logic [WIDTH-1:0]             req_val2,
  input  logic [TAG_W-1:0]             req_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH-1:0]             rsp_result,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic                         busy,
  output logic [NUM_UNITS-1:0]         fpu_en,
  output logic [NUM_UNITS*FUNCT_W-1:0] fpu_funct,
  output logic [NUM_UNITS*WIDTH-1:0]   fpu_x1,
  output logic [NUM_UNITS*WIDTH-1:0]   fpu_x2,
  input  logic [NUM_UNITS*WIDTH-1:0]   fpu_y,
  input  logic [NUM_UNITS-1:0]         fpu_valid,
  input  logic [NUM_UNITS-1:0]         fpu_idle
`ifdef FPU_DISPATCH_PERF_EN
  ,
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_stall
`endif
);

  localparam int UW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int REQ_W = FUNCT_W + 2 * WIDTH + TAG_W;
  localparam logic [UW-1:0] LAST_UNIT = UW'(NUM_UNITS - 1);
  localparam logic [UW-1:0] UNIT_ONE  = UW'(1);

  logic                       w_full;
  logic                       w_empty;
  logic                       w_dispatch;
  logic                       w_retire;
  logic [REQ_W-1:0]           w_head;
  logic [FUNCT_W-1:0]         w_head_funct;
  logic [WIDTH-1:0]           w_head_val1;
  logic [WIDTH-1:0]           w_head_val2;
  logic [TAG_W-1:0]           w_head_tag;
  logic [UW-1:0]              r_issue_ptr;
  logic [UW-1:0]              r_retire_ptr;
  logic [NUM_UNITS-1:0]       w_slot_idle;
  logic [NUM_UNITS-1:0]       w_slot_done;
  logic [NUM_UNITS*WIDTH-1:0] w_hold_y;
  logic [NUM_UNITS*TAG_W-1:0] w_hold_tag;

  fpu_dispatch_fifo #(
    .DATA_W (REQ_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_push    (req_valid),
    .i_data    ({req_funct, req_val1, req_val2, req_tag}),
    .i_pop     (w_dispatch),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign {w_head_funct, w_head_val1, w_head_val2, w_head_tag} = w_head;

  assign req_ready  = !w_full;
  // Only the unit under issue_ptr may start, which keeps issue order round-robin
  assign w_dispatch = !w_empty && w_slot_idle[r_issue_ptr] && fpu_idle[r_issue_ptr];
  // Only the oldest outstanding slot may retire, which keeps results in issue order
  assign rsp_valid  = w_slot_done[r_retire_ptr];
  assign w_retire   = rsp_valid && rsp_ready;
  assign rsp_result = w_hold_y[r_retire_ptr*WIDTH +: WIDTH];
  assign rsp_tag    = w_hold_tag[r_retire_ptr*TAG_W +: TAG_W];
  assign busy       = !w_empty || !(&w_slot_idle);

  // Issue and retire pointers walk the units round-robin
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_ptr  <= '0;
      r_retire_ptr <= '0;
    end else begin
      if (w_dispatch) r_issue_ptr  <= (r_issue_ptr == LAST_UNIT) ? '0 : r_issue_ptr + UNIT_ONE;
      if (w_retire)   r_retire_ptr <= (r_retire_ptr == LAST_UNIT) ? '0 : r_retire_ptr + UNIT_ONE;
    end
  end

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_slot
    slot_state_t        r_state;
    slot_state_t        w_state_nxt;
    logic               r_en;
    logic [FUNCT_W-1:0] r_funct;
    logic [WIDTH-1:0]   r_x1;
    logic [WIDTH-1:0]   r_x2;
    logic [WIDTH-1:0]   r_y;
    logic [TAG_W-1:0]   r_tag;
    logic               w_issue_here;
    logic               w_retire_here;

    assign w_issue_here  = w_dispatch && (r_issue_ptr == UW'(k));
    assign w_retire_here = w_retire && (r_retire_ptr == UW'(k));

    // Slot next state; a result pulse outside BUSY is dropped
    always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
        IDLE:    if (w_issue_here)  w_state_nxt = BUSY;
        BUSY:    if (fpu_valid[k])  w_state_nxt = DONE;
        DONE:    if (w_retire_here) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end

    // Slot state register
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
    end

    // Start pulse, operands held from dispatch until the next dispatch, result hold
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_en    <= 1'b0;
        r_funct <= '0;
        r_x1    <= WIDTH'(FPU_ONE);
        r_x2    <= WIDTH'(FPU_ONE);
        r_y     <= '0;
        r_tag   <= '0;
      end else begin
        r_en <= w_issue_here;
        if (w_issue_here) begin
          r_funct <= w_head_funct;
          r_x1    <= w_head_val1;
          r_x2    <= w_head_val2;
          r_tag   <= w_head_tag;
        end
        if (r_state == BUSY && fpu_valid[k]) r_y <= fpu_y[k*WIDTH +: WIDTH];
      end
    end

    assign w_slot_idle[k]                  = (r_state == IDLE);
    assign w_slot_done[k]                  = (r_state == DONE);
    assign fpu_en[k]                       = r_en;
    assign fpu_funct[k*FUNCT_W +: FUNCT_W] = r_funct;
    assign fpu_x1[k*WIDTH +: WIDTH]        = r_x1;
    assign fpu_x2[k*WIDTH +: WIDTH]        = r_x2;
    assign w_hold_y[k*WIDTH +: WIDTH]      = r_y;
    assign w_hold_tag[k*TAG_W +: TAG_W]    = r_tag;
  end

`ifdef FPU_DISPATCH_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  // Dispatch count and cycles where the core was refused by a full queue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_dispatch)             r_perf_issued <= r_perf_issued + 32'd1;
      if (req_valid && !req_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_fpu_dispatch_queue.sv
// tb/tb_fpu_dispatch_queue.sv - scoreboard bench for fpu_dispatch_queue with behavioural FPUs
module tb_fpu_dispatch_queue;
  import fpu_dispatch_pkg::*;

  localparam int NU = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [4:0]      req_funct = '0;
  logic [31:0]     req_val1 = '0;
  logic [31:0]     req_val2 = '0;
  logic [4:0]      req_tag = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [31:0]     rsp_result;
  logic [4:0]      rsp_tag;
  logic            busy;
  logic [NU-1:0]   fpu_en;
  logic [NU*5-1:0] fpu_funct;
  logic [NU*32-1:0] fpu_x1;
  logic [NU*32-1:0] fpu_x2;
  logic [NU*32-1:0] fpu_y = '0;
  logic [NU-1:0]   fpu_valid = '0;
  logic [NU-1:0]   fpu_idle = '1;
`ifdef FPU_DISPATCH_PERF_EN
  logic [31:0]     perf_issued;
  logic [31:0]     perf_stall;
`endif

  always #5 clock = ~clock;

  fpu_dispatch_queue #(
    .WIDTH(32), .FUNCT_W(5), .TAG_W(5), .NUM_UNITS(NU), .DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_val1(req_val1), .req_val2(req_val2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_tag(rsp_tag),
    .busy(busy), .fpu_en(fpu_en), .fpu_funct(fpu_funct), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
    .fpu_y(fpu_y), .fpu_valid(fpu_valid), .fpu_idle(fpu_idle)
`ifdef FPU_DISPATCH_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Single-precision arithmetic for normal numbers through double precision
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behaviour of every FPU: funct 0 is FP add, other codes a fixed mixing function
  function automatic logic [31:0] fp_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f == 5'd0) return r2s(s2r(a) + s2r(b));
    return a ^ {b[15:0], b[31:16]} ^ {27'd0, f};
  endfunction

  // Behavioural FPUs: latency L means fpu_valid L cycles after fpu_en
  int  lat [NU];
  bit  lat_rand = 1'b0;
  int  cnt [NU];
  bit  run [NU];
  logic [31:0] res [NU];

  always @(posedge clock) begin
    #1;
    for (int k = 0; k < NU; k++) begin
      fpu_valid[k] = 1'b0;
      if (run[k]) begin
        cnt[k]--;
        if (cnt[k] == 0) begin
          fpu_valid[k] = 1'b1;
          fpu_y[k*32 +: 32] = res[k];
          run[k] = 1'b0;
          fpu_idle[k] = 1'b1;
        end
      end
      if (fpu_en[k]) begin
        run[k] = 1'b1;
        cnt[k] = lat_rand ? int'($urandom_range(1, 5)) : lat[k];
        fpu_idle[k] = 1'b0;
        res[k] = fp_op(fpu_funct[k*5 +: 5], fpu_x1[k*32 +: 32], fpu_x2[k*32 +: 32]);
      end
    end
  end

  // Reference model: requests leave in push order, dispatch round-robin, results in push order
  typedef struct packed { logic [31:0] res; logic [4:0] tag; } rsp_t;
  fpu_req_t    exp_disp [$];
  rsp_t        exp_rsp [$];
  logic [4:0]  got_tags [$];
  int          next_unit = 0;
  logic [31:0] last_x1 [NU];
  logic [31:0] last_x2 [NU];
  logic [4:0]  last_f [NU];
  int          n_push = 0, n_rsp = 0, n_disp = 0, n_stall = 0;
  fpu_req_t    d;
  rsp_t        e;

  task automatic model_reset();
    exp_disp.delete();
    exp_rsp.delete();
    next_unit = 0;
    n_disp = 0;
    n_stall = 0;
    for (int k = 0; k < NU; k++) begin
      last_x1[k] = FPU_ONE;
      last_x2[k] = FPU_ONE;
      last_f[k]  = '0;
    end
  endtask

  // Monitor: records accepted requests and checks dispatches, held operands and responses
  always @(negedge clock) begin
    if (reset_n) begin
      if (req_valid && req_ready) begin
        exp_disp.push_back({req_funct, req_val1, req_val2, req_tag});
        exp_rsp.push_back({fp_op(req_funct, req_val1, req_val2), req_tag});
        n_push++;
      end
      if (req_valid && !req_ready) n_stall++;
      for (int k = 0; k < NU; k++) begin
        if (fpu_en[k]) begin
          chk("dispatch_unit", 64'(k), 64'(next_unit));
          if (exp_disp.size() == 0) chk("dispatch_unexpected", 64'd1, 64'd0);
          else begin
            d = exp_disp.pop_front();
            last_x1[k] = d.val1;
            last_x2[k] = d.val2;
            last_f[k]  = d.funct;
          end
          next_unit = (next_unit + 1) % NU;
          n_disp++;
        end
        chk("operand_x1", 64'(fpu_x1[k*32 +: 32]), 64'(last_x1[k]));
        chk("operand_x2", 64'(fpu_x2[k*32 +: 32]), 64'(last_x2[k]));
        chk("operand_funct", 64'(fpu_funct[k*5 +: 5]), 64'(last_f[k]));
      end
      if (rsp_valid && rsp_ready) begin
        got_tags.push_back(rsp_tag);
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        end
        n_rsp++;
      end
    end
  end

  task automatic push_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    int  n;
    bit  acc;
    n = 0;
    req_valid = 1'b1;
    req_funct = f;
    req_val1  = a;
    req_val2  = b;
    req_tag   = t;
    do begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int start_push, start_rsp, ub, n, rv;
    bit seen;
    logic [31:0] x1_snap;

    model_reset();
    lat[0] = 3;
    lat[1] = 3;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_fpu_en", 64'(fpu_en), 64'd0);
    chk("reset_x1", 64'(fpu_x1), {2{FPU_ONE}});
    chk("reset_x2", 64'(fpu_x2), {2{FPU_ONE}});
    chk("reset_funct", 64'(fpu_funct), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single op: 1.0 + 2.0, tag 7, FPU latency 3
    push_op(5'd0, 32'h3f800000, 32'h40000000, 5'd7);
    chk("single_en_not_yet", 64'(fpu_en), 64'd0);
    @(posedge clock);
    #1;
    chk("single_en_cycle", 64'(fpu_en), 64'b01);
    chk("single_x1", 64'(fpu_x1[31:0]), 64'h3f800000);
    chk("single_x2", 64'(fpu_x2[31:0]), 64'h40000000);
    repeat (3) @(posedge clock);
    #1;
    chk("single_rsp_not_yet", 64'(rsp_valid), 64'd0);
    @(posedge clock);
    #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_result", 64'(rsp_result), 64'h40400000);
    chk("single_rsp_tag", 64'(rsp_tag), 64'd7);
    wait_idle("single_busy_clear");

    // Out-of-order completion: first op slow, second op fast
    got_tags.delete();
    lat[next_unit] = 6;
    lat[(next_unit + 1) % NU] = 1;
    push_op(5'd3, $urandom, $urandom, 5'd1);
    push_op(5'd4, $urandom, $urandom, 5'd2);
    wait_idle("ooo_busy_clear");
    chk("ooo_count", 64'(got_tags.size()), 64'd2);
    if (got_tags.size() == 2) begin
      chk("ooo_first_tag", 64'(got_tags[0]), 64'd1);
      chk("ooo_second_tag", 64'(got_tags[1]), 64'd2);
    end

    // Operand hold while busy
    ub = next_unit;
    lat[ub] = 8;
    push_op(5'd9, 32'hdeadbeef, 32'h12345678, 5'd3);
    @(posedge clock);
    #1;
    x1_snap = fpu_x1[ub*32 +: 32];
    chk("hold_dispatched", 64'(x1_snap), 64'hdeadbeef);
    repeat (6) begin
      req_val1 = $urandom;
      @(posedge clock);
      #1;
    end
    chk("hold_x1_stable", 64'(fpu_x1[ub*32 +: 32]), 64'(x1_snap));
    wait_idle("hold_busy_clear");

    // Backpressure: responses blocked, DEPTH + NUM_UNITS ops fit
    lat[0] = 1;
    lat[1] = 1;
    rsp_ready = 1'b0;
    start_push = n_push;
    start_rsp = n_rsp;
    req_valid = 1'b1;
    repeat (20) begin
      req_funct = 5'($urandom_range(1, 31));
      req_val1 = $urandom;
      req_val2 = $urandom;
      req_tag = 5'($urandom);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 64'(n_push - start_push), 64'd6);
    chk("bp_req_ready_low", 64'(req_ready), 64'd0);
    chk("bp_no_rsp", 64'(n_rsp - start_rsp), 64'd0);
    rsp_ready = 1'b1;
    wait_idle("bp_busy_clear");
    chk("bp_drained", 64'(n_rsp - start_rsp), 64'd6);

    // Randomized traffic with random FPU latencies
    lat_rand = 1'b1;
    repeat (400) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_funct = 5'($urandom_range(1, 31));
      req_val1 = $urandom;
      req_val2 = $urandom;
      req_tag = 5'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("rand_busy_clear");
    chk("rand_sb_empty", 64'(exp_rsp.size()), 64'd0);
    chk("rand_all_retired", 64'(n_rsp), 64'(n_push));
    lat_rand = 1'b0;

`ifdef FPU_DISPATCH_PERF_EN
    chk("perf_issued", 64'(perf_issued), 64'(n_disp));
    chk("perf_stall", 64'(perf_stall), 64'(n_stall));
`endif

    // Reset while the slow unit is busy
    lat[next_unit] = 2;
    ub = (next_unit + 1) % NU;
    lat[ub] = 10;
    push_op(5'd5, $urandom, $urandom, 5'd11);
    push_op(5'd6, $urandom, $urandom, 5'd12);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      seen = fpu_en[ub];
      @(posedge clock);
      #1;
      n++;
    end
    chk("rst_unit_started", 64'(seen), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fpu_en", 64'(fpu_en), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_x1", 64'(fpu_x1), {2{FPU_ONE}});
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    rv = 0;
    repeat (30) begin
      @(negedge clock);
      if (fpu_valid[ub]) seen = 1'b1;
      if (rsp_valid) rv++;
    end
    chk("rst_late_valid_seen", 64'(seen), 64'd1);
    chk("rst_no_rsp", 64'(rv), 64'd0);
    chk("rst_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
